weight_mem_responder: RTL

Memory-side responder for the weight read channel: accepts word read requests from the arbiter, reads a single-port synchronous weight SRAM, and returns address-tagged data beats to the arbiter with full valid/ready backpressure. Sits between the bus arbiter and the on-chip weight SRAM, serving both the 3×3 and 1×1 weight fetch bursts issued by the weight bus interface unit.

---
 rtl/weight_mem_pkg.sv | 18 +
 rtl/weight_mem_responder_if.sv | 24 ++
 rtl/weight_rsp_fifo.sv | 60 ++++++
 rtl/weight_mem_responder.sv | 109 ++++++++++
 4 files changed

// File: rtl/weight_mem_pkg.sv
// Shared types and constants for the weight SRAM read responder.
package weight_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } state_t;

  localparam logic [31:0] RSP_ERR_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } rsp_entry_t;

endpackage

// File: rtl/weight_mem_responder_if.sv
// Request/response handshake between the bus arbiter (master) and the weight memory responder (slave).
interface weight_mem_responder_if;

  logic        req_req;
  logic [31:0] req_addr;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic        rsp_err;

  modport master (
    output req_req, req_addr, req_vld, rsp_rdy,
    input  req_rdy, rsp_addr, rsp_data, rsp_vld, rsp_err
  );

  modport slave (
    input  req_req, req_addr, req_vld, rsp_rdy,
    output req_rdy, rsp_addr, rsp_data, rsp_vld, rsp_err
  );

endinterface

// File: rtl/weight_rsp_fifo.sv
// Synchronous FIFO with a registered head word; DEPTH must be a power of two.
module weight_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    count;
  logic             do_pop;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign do_pop     = pop & ~empty;
  assign rd_ptr_nxt = rd_ptr + PW'(1);

  // NOTE: storage has no reset; validity is tracked by count, and the head register supplies the reset-visible value.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr_nxt;
      count <= count + CW'(push) - CW'(do_pop);
      // Head only moves on a pop or on a push into an empty FIFO, so it holds under backpressure.
      if (do_pop) begin
        if (count == CW'(1)) begin
          if (push) head <= wr_data;
        end else begin
          head <= mem[rd_ptr_nxt];
        end
      end else if (empty && push) begin
        head <= wr_data;
      end
    end
  end

endmodule

// File: rtl/weight_mem_responder.sv
// Weight SRAM read responder: credit-limited request accept, one-cycle SRAM read, in-order response FIFO.
// Optional macro WEIGHT_RSP_ERR_EN enables misaligned/out-of-range request detection.
module weight_mem_responder #(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int          MEM_AW     = 14,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  weight_mem_responder_if.slave  bus,
  output logic                   mem_en,
  output logic [MEM_AW-1:0]      mem_addr,
  input  logic [31:0]            mem_rdata,
  output logic                   busy,
  output logic [15:0]            rsp_cnt
);

  import weight_mem_pkg::*;

  localparam int OW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     outstanding_d;
  logic              accept;
  logic              pop;
  logic              req_err;
  logic [MEM_AW-1:0] word_idx;
  logic              s1_vld;
  logic              s1_err;
  logic [31:0]       s1_addr;
  logic              fifo_full;
  logic              fifo_empty;
  rsp_entry_t        push_entry;
  rsp_entry_t        head_entry;

  assign word_idx = MEM_AW'((bus.req_addr - ADDR_BASE) >> 2);

`ifdef WEIGHT_RSP_ERR_EN
  logic [31:0] offset;
  assign offset  = bus.req_addr - ADDR_BASE;
  assign req_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < ADDR_BASE) ||
                   ((offset >> (MEM_AW + 2)) != 32'd0);
`else
  assign req_err = 1'b0;
`endif

  assign bus.req_rdy   = (state == ACTIVE) && bus.req_req && (outstanding < OW'(FIFO_DEPTH));
  assign accept        = bus.req_vld & bus.req_rdy;
  assign pop           = bus.rsp_vld & bus.rsp_rdy;
  assign outstanding_d = outstanding + OW'(accept) - OW'(pop);

  assign mem_en   = accept & ~req_err;
  assign mem_addr = mem_en ? word_idx : '0;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      outstanding <= '0;
      s1_vld      <= 1'b0;
      s1_err      <= 1'b0;
      s1_addr     <= '0;
      rsp_cnt     <= '0;
    end else begin
      outstanding <= outstanding_d;
      s1_vld      <= accept;
      if (accept) begin
        s1_addr <= bus.req_addr;
        s1_err  <= req_err;
      end
      if (pop) rsp_cnt <= rsp_cnt + 16'd1;
      case (state)
        IDLE:    if (bus.req_req)  state <= ACTIVE;
        ACTIVE:  if (!bus.req_req) state <= DRAIN;
        // Leave on the final pop itself so busy drops the cycle after the last response.
        DRAIN:   if (outstanding_d == '0) state <= bus.req_req ? ACTIVE : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign push_entry = '{addr: s1_addr,
                        data: s1_err ? RSP_ERR_DATA : mem_rdata,
                        err:  s1_err};

  weight_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(rsp_entry_t))
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (s1_vld),
    .wr_data (push_entry),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head_entry)
  );

  assign bus.rsp_vld  = ~fifo_empty;
  assign bus.rsp_addr = head_entry.addr;
  assign bus.rsp_data = head_entry.data;
  assign bus.rsp_err  = head_entry.err;

  // Credits bound in-flight reads plus occupancy by the FIFO depth, so a push into a full FIFO is a design bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(s1_vld && fifo_full));

endmodule
